// File: rtl/simple_adder_accumulator.sv
// Sums BURST_LEN 9-bit adder results ({cout,sum}) into an ACC_W-bit total and
// presents the total, a sticky overflow flag and the beat count over a valid/ready handshake.
module simple_adder_accumulator #(
  parameter int ACC_W     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sum,
  input  logic             in_cout,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic [7:0]       out_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  typedef struct packed {
    logic       cout;
    logic [7:0] sum;
  } beat_t;

  localparam logic [7:0] LAST = 8'(BURST_LEN - 1);

  state_t           state;
  beat_t            beat;
  logic             accept;
  logic [ACC_W:0]   nxt;

  assign beat   = '{cout: in_cout, sum: in_sum};
  // in_ready is a register, so acceptance never depends combinationally on in_valid
  // through the ready path.
  assign accept = in_valid & in_ready & ~clear;
  assign nxt    = {1'b0, out_total} + {{(ACC_W-8){1'b0}}, beat};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= IDLE;
      out_total <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_total <= nxt[ACC_W-1:0];
            out_ovf   <= nxt[ACC_W];
            out_count <= 8'd1;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            out_total <= nxt[ACC_W-1:0];
            out_ovf   <= out_ovf | nxt[ACC_W];
            out_count <= out_count + 8'd1;
            if (out_count == LAST) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Result is frozen until taken; beats offered here are dropped.
          if (out_ready) begin
            out_total <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_adder_accumulator.sv
// Directed bench for simple_adder_accumulator at ACC_W=16 and ACC_W=10 sharing stimulus,
// checked every cycle against a burst-level arithmetic model plus literal expectations.
module tb_simple_adder_accumulator;

  logic clk = 1'b0;
  logic rst, in_valid, in_cout, clear, out_ready;
  logic [7:0] in_sum;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [15:0] a_out_total;
  logic [7:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [9:0]  b_out_total;
  logic [7:0]  b_out_count;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: true (unbounded) burst sum, beats taken, and whether a result is pending.
  int m_tot = 0;
  int m_cnt = 0;
  bit m_hold = 1'b0;

  always #5 clk = ~clk;

  simple_adder_accumulator #(.ACC_W(16), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .clear(clear),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_total(a_out_total), .out_ovf(a_out_ovf), .out_count(a_out_count));

  simple_adder_accumulator #(.ACC_W(10), .BURST_LEN(4)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .clear(clear),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_total(b_out_total), .out_ovf(b_out_ovf), .out_count(b_out_count));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst || clear) begin
      m_tot = 0; m_cnt = 0; m_hold = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_tot = 0; m_cnt = 0; m_hold = 1'b0;
      end
    end else if (in_valid) begin
      m_tot += {in_cout, in_sum};
      m_cnt++;
      if (m_cnt == 4) m_hold = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_in_ready",  a_in_ready,  !m_hold);
      check("a_out_valid", a_out_valid, m_hold);
      check("a_out_total", a_out_total, m_tot % 65536);
      check("a_out_ovf",   a_out_ovf,   m_tot >= 65536);
      check("a_out_count", a_out_count, m_cnt);
      check("b_in_ready",  b_in_ready,  !m_hold);
      check("b_out_valid", b_out_valid, m_hold);
      check("b_out_total", b_out_total, m_tot % 1024);
      check("b_out_ovf",   b_out_ovf,   m_tot >= 1024);
      check("b_out_count", b_out_count, m_cnt);
    end
  end

  // Drive one cycle of inputs, then settle just past the edge.
  task automatic cyc(input bit v, input logic [8:0] b, input bit clr, input bit ordy);
    in_valid = v; {in_cout, in_sum} = b; clear = clr; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; clear = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_ready", a_in_ready, 1'b1);
    check("reset_valid", a_out_valid, 1'b0);
    check("reset_total", a_out_total, 16'h0000);
    chk_en = 1'b1;
    rst = 1'b0;

    // Basic burst
    cyc(1, 9'h010, 0, 0);
    cyc(1, 9'h020, 0, 0);
    cyc(1, 9'h030, 0, 0);
    check("basic_not_yet_valid", a_out_valid, 1'b0);
    cyc(1, 9'h040, 0, 0);
    check("basic_valid", a_out_valid, 1'b1);
    check("basic_total", a_out_total, 16'h00A0);
    check("basic_ovf",   a_out_ovf, 1'b0);
    check("basic_count", a_out_count, 8'd4);
    cyc(0, 9'h000, 0, 1);
    check("basic_done", a_out_valid, 1'b0);

    // Carry inclusion and 10-bit overflow
    repeat (4) cyc(1, 9'h1FF, 0, 0);
    check("carry_total16", a_out_total, 16'h07FC);
    check("carry_ovf16",   a_out_ovf, 1'b0);
    check("ovf_total10",   b_out_total, 10'h3FC);
    check("ovf_ovf10",     b_out_ovf, 1'b1);

    // Backpressure with in_valid held high
    repeat (5) begin
      cyc(1, 9'h005, 0, 0);
      check("bp_ready", a_in_ready, 1'b0);
      check("bp_total", a_out_total, 16'h07FC);
      check("bp_count", a_out_count, 8'd4);
    end
    cyc(1, 9'h005, 0, 1);
    check("bp_hs_count", a_out_count, 8'd0);
    cyc(1, 9'h005, 0, 0);
    check("bp_first_beat", a_out_total, 16'h0005);

    // Gap, second beat, then clear alongside a valid beat
    cyc(0, 9'h0AA, 0, 0);
    cyc(0, 9'h0AA, 0, 0);
    check("gap_count", a_out_count, 8'd1);
    cyc(1, 9'h007, 0, 0);
    cyc(1, 9'h009, 1, 0);
    check("clr_count", a_out_count, 8'd0);
    check("clr_total", a_out_total, 16'h0000);
    repeat (4) cyc(1, 9'h001, 0, 0);
    check("clr_after_total", a_out_total, 16'h0004);
    check("clr_after_valid", a_out_valid, 1'b1);

    // Clear overrides the output handshake
    cyc(0, 9'h000, 1, 1);
    check("clr_hold_valid", a_out_valid, 1'b0);

    // Reset while holding
    repeat (4) cyc(1, 9'h123, 0, 0);
    check("rst_pre_valid", a_out_valid, 1'b1);
    rst = 1'b1;
    cyc(1, 9'h123, 1, 1);
    rst = 1'b0;
    check("rst_hold_valid", a_out_valid, 1'b0);
    check("rst_hold_total", a_out_total, 16'h0000);
    check("rst_hold_ready", a_in_ready, 1'b1);
    cyc(0, 9'h000, 0, 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simple_adder_accumulator.md
SIMPLE_ADDER_ACCUMULATOR -- requirements
Module: simple_adder_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 16, giving the accumulator width in bits (legal range 10..32).
REQ-002 The block SHALL have parameter BURST_LEN, default 4, giving the number of adder results summed per burst (legal range 2..255).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  the upstream adder result is present this cycle.
REQ-006 in_ready  output  1  the block can accept an adder result this cycle.
REQ-007 in_sum  input  8  the 8-bit sum from the upstream 8-bit adder.
REQ-008 in_cout  input  1  the carry-out from the upstream 8-bit adder.
REQ-009 clear  input  1  synchronous abort of the current burst.
REQ-010 out_valid  output  1  a burst result is presented.
REQ-011 out_ready  input  1  the downstream consumer takes the result.
REQ-012 out_total  output  ACC_W  the burst sum, modulo 2^ACC_W.
REQ-013 out_ovf  output  1  the burst sum exceeded 2^ACC_W-1.
REQ-014 out_count  output  8  the number of beats accepted in the current burst.

Function
REQ-015 A beat SHALL be accepted only on a cycle where in_valid=1, in_ready=1 and clear=0.
REQ-016 Each accepted beat SHALL add the 9-bit value {in_cout, in_sum} (0..511), zero-extended to ACC_W, to the accumulator.
REQ-017 The block SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; it SHALL be a registered or state-decoded signal with no combinational path from in_valid.
REQ-019 Transitions SHALL be as follows:
- IDLE->ACCUM on the first accepted beat.
- ACCUM->HOLD on the accepted beat that brings the count to BURST_LEN.
- HOLD->IDLE when out_valid=1 and out_ready=1.
REQ-020 out_valid SHALL be 1 exactly while in HOLD; it SHALL rise on the cycle after the final beat is accepted (1-cycle latency).
REQ-021 While out_valid=1, out_total, out_ovf and out_count SHALL remain stable until the handshake completes, regardless of out_ready.
REQ-022 out_ovf SHALL be sticky within a burst: it is set by any addition producing a carry out of bit ACC_W-1, and is cleared only at burst start, on clear, or on reset.
REQ-023 out_count SHALL increment by 1 per accepted beat and SHALL equal BURST_LEN while in HOLD.
REQ-024 On the HOLD->IDLE handshake, the accumulator, out_ovf and out_count SHALL clear to 0 on the same edge.
REQ-025 In HOLD, in_valid SHALL be ignored (no acceptance), including on the handshake cycle itself; the next beat can be accepted one cycle after the handshake.
REQ-026 When clear=1 in any state, the block SHALL go to IDLE on the next edge and zero the accumulator, out_count and out_ovf, with no output produced; clear SHALL override a simultaneous accept or output handshake.
REQ-027 Gaps where in_valid=0 in ACCUM SHALL hold all state unchanged with no timeout.

Reset
REQ-028 rst=1 at a rising edge SHALL force state IDLE, with in_ready=1, out_valid=0, out_total=0, out_ovf=0 and out_count=0, and rst SHALL take priority over clear and over all handshakes.
REQ-029 Reset asserted mid-burst or during HOLD SHALL discard the partial or pending result entirely.

Verification
REQ-030 The bench SHALL cover the following directed scenarios (defaults ACC_W=16, BURST_LEN=4 unless stated):
- Basic burst: beats {cout,sum} = 0x010, 0x020, 0x030, 0x040 back-to-back -> out_valid high 1 cycle after the 4th beat, out_total=0x00A0, out_ovf=0, out_count=4.
- Carry inclusion: beats 0x1FF x4 -> out_total=0x07FC, out_ovf=0.
- Overflow (ACC_W=10): beats 0x1FF x4 -> out_total=0x3FC, out_ovf=1.
- Backpressure: out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0, outputs stable, no beat accepted; the first beat is accepted the cycle after out_ready=1.
- Clear mid-burst: 2 beats, then clear=1 together with in_valid=1 -> that beat is not accepted, the block returns to IDLE with out_count=0; the next 4 beats of 0x001 give out_total=0x0004.
- Reset in HOLD: rst=1 while out_valid=1 -> the next cycle shows out_valid=0, out_total=0 and in_ready=1.
